// File: rtl/mips_multicycle_ctrl.sv
// Main-control FSM for the multi-cycle MIPS datapath: sequences fetch/decode/execute/
// memory/write-back over one shared ALU and one unified memory port.
module mips_multicycle_ctrl #(
   parameter int COUNT_W = 32
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [5:0]         opcode,
   input  logic [5:0]         funct,
   input  logic               zero,
   input  logic               mem_ready,
   output logic               mem_req,
   output logic               mem_we,
   output logic               iord,
   output logic               ir_we,
   output logic               mdr_we,
   output logic               pc_we,
   output logic [1:0]         pc_src,
   output logic               alu_src_a,
   output logic [1:0]         alu_src_b,
   output logic [1:0]         alu_op,
   output logic               reg_we,
   output logic               reg_dst,
   output logic               mem_to_reg,
   output logic               illegal,
   output logic [COUNT_W-1:0] retired
);

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_ADDI  = 6'b001000;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_J     = 6'b000010;

   typedef enum logic [3:0] {
      S_FETCH,
      S_DECODE,
      S_MEMADR,
      S_MEMRD,
      S_MEMWB,
      S_MEMWR,
      S_RTEXEC,
      S_RTWB,
      S_ADDIEXEC,
      S_ADDIWB,
      S_BRANCH,
      S_JUMP,
      S_TRAP
   } state_t;

   // Registered Moore controls; the *_st flags mark states whose enables are
   // qualified by mem_ready or zero at the output.
   typedef struct packed {
      logic       mem_req;
      logic       mem_we;
      logic       iord;
      logic       fetch_st;
      logic       memrd_st;
      logic       branch_st;
      logic       jump_st;
      logic [1:0] pc_src;
      logic       alu_src_a;
      logic [1:0] alu_src_b;
      logic [1:0] alu_op;
      logic       reg_we;
      logic       reg_dst;
      logic       mem_to_reg;
   } ctl_t;

   state_t             state;
   state_t             state_nxt;
   ctl_t               ctl_q;
   logic               retire;
   logic               illegal_q;
   logic [COUNT_W-1:0] retired_q;

   // funct feeds the ALU decoder directly; it plays no part in sequencing.
   logic unused_funct;
   assign unused_funct = ^funct;

   function automatic ctl_t state_ctl(input state_t s);
      ctl_t c;
      c = '0;
      case (s)
         S_FETCH: begin
            c.mem_req   = 1'b1;
            c.fetch_st  = 1'b1;
            c.alu_src_b = 2'b01;
         end
         S_DECODE: begin
            c.alu_src_b = 2'b11;
         end
         S_MEMADR, S_ADDIEXEC: begin
            c.alu_src_a = 1'b1;
            c.alu_src_b = 2'b10;
         end
         S_MEMRD: begin
            c.mem_req  = 1'b1;
            c.iord     = 1'b1;
            c.memrd_st = 1'b1;
         end
         S_MEMWB: begin
            c.reg_we     = 1'b1;
            c.mem_to_reg = 1'b1;
         end
         S_MEMWR: begin
            c.mem_req = 1'b1;
            c.mem_we  = 1'b1;
            c.iord    = 1'b1;
         end
         S_RTEXEC: begin
            c.alu_src_a = 1'b1;
            c.alu_op    = 2'b10;
         end
         S_RTWB: begin
            c.reg_we  = 1'b1;
            c.reg_dst = 1'b1;
         end
         S_ADDIWB: begin
            c.reg_we = 1'b1;
         end
         S_BRANCH: begin
            c.alu_src_a = 1'b1;
            c.alu_op    = 2'b01;
            c.pc_src    = 2'b01;
            c.branch_st = 1'b1;
         end
         S_JUMP: begin
            c.pc_src  = 2'b10;
            c.jump_st = 1'b1;
         end
         default: c = '0;
      endcase
      return c;
   endfunction

   always_comb begin
      // NOTE: defaults first so every path assigns every variable; no latches.
      state_nxt = state;
      retire    = 1'b0;
      case (state)
         S_FETCH:  if (mem_ready) state_nxt = S_DECODE;
         S_DECODE: begin
            case (opcode)
               OP_RTYPE:     state_nxt = S_RTEXEC;
               OP_LW, OP_SW: state_nxt = S_MEMADR;
               OP_ADDI:      state_nxt = S_ADDIEXEC;
               OP_BEQ:       state_nxt = S_BRANCH;
               OP_J:         state_nxt = S_JUMP;
               default:      state_nxt = S_TRAP;
            endcase
         end
         S_MEMADR: state_nxt = (opcode == OP_LW) ? S_MEMRD : S_MEMWR;
         S_MEMRD:  if (mem_ready) state_nxt = S_MEMWB;
         S_MEMWR: begin
            if (mem_ready) begin
               state_nxt = S_FETCH;
               retire    = 1'b1;
            end
         end
         S_RTEXEC:   state_nxt = S_RTWB;
         S_ADDIEXEC: state_nxt = S_ADDIWB;
         S_MEMWB, S_RTWB, S_ADDIWB, S_BRANCH, S_JUMP: begin
            state_nxt = S_FETCH;
            retire    = 1'b1;
         end
         S_TRAP:  state_nxt = S_TRAP;
         default: state_nxt = S_FETCH;
      endcase
   end

   // Outputs are registered from the next state, so they are valid from the
   // first cycle of each state, including FETCH straight out of reset.
   always_ff @(posedge clk) begin
      // NOTE: non-blocking assignments for all sequential state.
      if (rst) begin
         state     <= S_FETCH;
         ctl_q     <= state_ctl(S_FETCH);
         retired_q <= '0;
         illegal_q <= 1'b0;
      end else begin
         state <= state_nxt;
         ctl_q <= state_ctl(state_nxt);
         if (retire) retired_q <= retired_q + COUNT_W'(1);
         if (state_nxt == S_TRAP) illegal_q <= 1'b1;
      end
   end

   // rst gates every control combinationally so an in-flight access drops at once.
   logic run;
   assign run = ~rst;

   assign mem_req    = ctl_q.mem_req    & run;
   assign mem_we     = ctl_q.mem_we     & run;
   assign iord       = ctl_q.iord       & run;
   assign ir_we      = ctl_q.fetch_st   & mem_ready & run;
   assign mdr_we     = ctl_q.memrd_st   & mem_ready & run;
   assign pc_we      = ((ctl_q.fetch_st & mem_ready) | (ctl_q.branch_st & zero) | ctl_q.jump_st) & run;
   assign pc_src     = ctl_q.pc_src     & {2{run}};
   assign alu_src_a  = ctl_q.alu_src_a  & run;
   assign alu_src_b  = ctl_q.alu_src_b  & {2{run}};
   assign alu_op     = ctl_q.alu_op     & {2{run}};
   assign reg_we     = ctl_q.reg_we     & run;
   assign reg_dst    = ctl_q.reg_dst    & run;
   assign mem_to_reg = ctl_q.mem_to_reg & run;
   assign illegal    = illegal_q;
   assign retired    = retired_q;

   a_we_needs_req: assert property (@(posedge clk) mem_we |-> mem_req);
   a_no_dual_write: assert property (@(posedge clk) !(reg_we && mem_we));

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Self-checking bench for mips_multicycle_ctrl: per-cycle output vectors from an
// instruction-level model, directed table, corner sequences and random mix.
module tb_mips_multicycle_ctrl;

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_ADDI  = 6'b001000;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_J     = 6'b000010;
   localparam logic [5:0] OP_BAD   = 6'b111111;

   logic        clk = 1'b0;
   logic        rst;
   logic [5:0]  opcode;
   logic [5:0]  funct;
   logic        zero;
   logic        mem_ready;
   logic        mem_req, mem_we, iord, ir_we, mdr_we, pc_we;
   logic [1:0]  pc_src;
   logic        alu_src_a;
   logic [1:0]  alu_src_b;
   logic [1:0]  alu_op;
   logic        reg_we, reg_dst, mem_to_reg, illegal;
   logic [31:0] retired;
   logic [3:0]  retired_s;
   logic [16:0] unused_small;

   mips_multicycle_ctrl dut (
      .clk(clk), .rst(rst), .opcode(opcode), .funct(funct), .zero(zero),
      .mem_ready(mem_ready), .mem_req(mem_req), .mem_we(mem_we), .iord(iord),
      .ir_we(ir_we), .mdr_we(mdr_we), .pc_we(pc_we), .pc_src(pc_src),
      .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
      .reg_we(reg_we), .reg_dst(reg_dst), .mem_to_reg(mem_to_reg),
      .illegal(illegal), .retired(retired)
   );

   mips_multicycle_ctrl #(.COUNT_W(4)) small_dut (
      .clk(clk), .rst(rst), .opcode(opcode), .funct(funct), .zero(zero),
      .mem_ready(mem_ready), .mem_req(unused_small[0]), .mem_we(unused_small[1]),
      .iord(unused_small[2]), .ir_we(unused_small[3]), .mdr_we(unused_small[4]),
      .pc_we(unused_small[5]), .pc_src(unused_small[7:6]), .alu_src_a(unused_small[8]),
      .alu_src_b(unused_small[10:9]), .alu_op(unused_small[12:11]),
      .reg_we(unused_small[13]), .reg_dst(unused_small[14]),
      .mem_to_reg(unused_small[15]), .illegal(unused_small[16]), .retired(retired_s)
   );

   always #5 clk = ~clk;

   typedef enum {
      P_FETCH, P_DECODE, P_MEMADR, P_MEMRD, P_MEMWB, P_MEMWR, P_RTEXEC,
      P_RTWB, P_ADDIEXEC, P_ADDIWB, P_BRANCH, P_JUMP, P_TRAP
   } phase_t;

   typedef struct packed {
      logic       mem_req;
      logic       mem_we;
      logic       iord;
      logic       ir_we;
      logic       mdr_we;
      logic       pc_we;
      logic [1:0] pc_src;
      logic       alu_src_a;
      logic [1:0] alu_src_b;
      logic [1:0] alu_op;
      logic       reg_we;
      logic       reg_dst;
      logic       mem_to_reg;
      logic       illegal;
   } vec_t;

   typedef struct {
      string      name;
      logic [5:0] op;
      bit         z;
      int         fw;
      int         mw;
      int         exp_cyc;
   } rec_t;

   int          n_checks = 0;
   int          n_err = 0;
   int unsigned model_ret = 0;
   bit          model_ill = 1'b0;
   int          cyc;
   int          ret_at;

   task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", name, got, exp);
      end
   endtask

   function automatic vec_t dut_vec();
      vec_t v;
      v.mem_req = mem_req;     v.mem_we = mem_we;       v.iord = iord;
      v.ir_we = ir_we;         v.mdr_we = mdr_we;       v.pc_we = pc_we;
      v.pc_src = pc_src;       v.alu_src_a = alu_src_a; v.alu_src_b = alu_src_b;
      v.alu_op = alu_op;       v.reg_we = reg_we;       v.reg_dst = reg_dst;
      v.mem_to_reg = mem_to_reg; v.illegal = illegal;
      return v;
   endfunction

   // Expected outputs for one cycle of a named step, straight from the state table.
   function automatic vec_t expect_vec(input phase_t p, input bit rdy, input bit z, input bit ill);
      vec_t v;
      v = '0;
      v.illegal = ill;
      case (p)
         P_FETCH:    begin v.mem_req = 1; v.alu_src_b = 2'b01; v.ir_we = rdy; v.pc_we = rdy; end
         P_DECODE:   v.alu_src_b = 2'b11;
         P_MEMADR:   begin v.alu_src_a = 1; v.alu_src_b = 2'b10; end
         P_MEMRD:    begin v.mem_req = 1; v.iord = 1; v.mdr_we = rdy; end
         P_MEMWB:    begin v.reg_we = 1; v.mem_to_reg = 1; end
         P_MEMWR:    begin v.mem_req = 1; v.mem_we = 1; v.iord = 1; end
         P_RTEXEC:   begin v.alu_src_a = 1; v.alu_op = 2'b10; end
         P_RTWB:     begin v.reg_we = 1; v.reg_dst = 1; end
         P_ADDIEXEC: begin v.alu_src_a = 1; v.alu_src_b = 2'b10; end
         P_ADDIWB:   v.reg_we = 1;
         P_BRANCH:   begin v.alu_src_a = 1; v.alu_op = 2'b01; v.pc_src = 2'b01; v.pc_we = z; end
         P_JUMP:     begin v.pc_src = 2'b10; v.pc_we = 1; end
         default:    ;
      endcase
      return v;
   endfunction

   function automatic bit rb();
      return bit'($urandom_range(0, 1));
   endfunction

   // One clock cycle: drive at negedge, compare, then note whether retired moved.
   task automatic step(input phase_t p, input bit rdy, input bit z);
      vec_t got, exp;
      mem_ready = rdy;
      zero      = z;
      if (p == P_TRAP) model_ill = 1'b1;
      #1;
      got = dut_vec();
      exp = expect_vec(p, rdy, z, model_ill);
      check($sformatf("cycle %0d %s", cyc, p.name()), 64'(got), 64'(exp));
      @(posedge clk);
      #1;
      cyc++;
      if (ret_at == 0 && retired != model_ret) ret_at = cyc;
      @(negedge clk);
   endtask

   task automatic run_instr(input logic [5:0] op, input bit z, input int fw, input int mw,
                            output int ret_cycles);
      bit legal;
      cyc    = 0;
      ret_at = 0;
      opcode = 6'($urandom);
      funct  = 6'($urandom);
      for (int i = 0; i < fw; i++) step(P_FETCH, 1'b0, rb());
      step(P_FETCH, 1'b1, rb());
      opcode = op;
      step(P_DECODE, rb(), rb());
      legal = 1'b1;
      case (op)
         OP_LW: begin
            step(P_MEMADR, rb(), rb());
            for (int i = 0; i < mw; i++) step(P_MEMRD, 1'b0, rb());
            step(P_MEMRD, 1'b1, rb());
            step(P_MEMWB, rb(), rb());
         end
         OP_SW: begin
            step(P_MEMADR, rb(), rb());
            for (int i = 0; i < mw; i++) step(P_MEMWR, 1'b0, rb());
            step(P_MEMWR, 1'b1, rb());
         end
         OP_RTYPE: begin step(P_RTEXEC, rb(), rb()); step(P_RTWB, rb(), rb()); end
         OP_ADDI:  begin step(P_ADDIEXEC, rb(), rb()); step(P_ADDIWB, rb(), rb()); end
         OP_BEQ:   step(P_BRANCH, rb(), z);
         OP_J:     step(P_JUMP, rb(), rb());
         default: begin
            legal = 1'b0;
            for (int i = 0; i < 20; i++) step(P_TRAP, rb(), rb());
         end
      endcase
      if (legal) model_ret++;
      ret_cycles = ret_at;
      check("retired", 64'(retired), 64'(model_ret));
      check("retired_w4", 64'(retired_s), 64'(model_ret[3:0]));
   endtask

   task automatic do_reset(input int n);
      vec_t m;
      m = '1;
      m.illegal = 1'b0;
      for (int i = 0; i < n; i++) begin
         rst       = 1'b1;
         mem_ready = 1'b1;
         zero      = rb();
         #1;
         check("rst_ctl_drop", 64'(dut_vec() & m), 64'(0));
         @(posedge clk);
         #1;
         check("rst_outputs", 64'(dut_vec()), 64'(0));
         check("rst_retired", 64'(retired), 64'(0));
         @(negedge clk);
      end
      rst       = 1'b0;
      model_ret = 0;
      model_ill = 1'b0;
   endtask

   function automatic int base_cycles(input logic [5:0] op);
      case (op)
         OP_LW:                    return 5;
         OP_SW, OP_RTYPE, OP_ADDI: return 4;
         default:                  return 3;
      endcase
   endfunction

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      rec_t       tbl[10];
      logic [5:0] ops[6];
      int         rc;

      tbl[0] = '{"rtype",      OP_RTYPE, 1'b0, 0, 0, 4};
      tbl[1] = '{"lw",         OP_LW,    1'b0, 0, 0, 5};
      tbl[2] = '{"sw",         OP_SW,    1'b0, 0, 0, 4};
      tbl[3] = '{"sw_wait3",   OP_SW,    1'b0, 0, 3, 7};
      tbl[4] = '{"addi",       OP_ADDI,  1'b0, 0, 0, 4};
      tbl[5] = '{"beq_taken",  OP_BEQ,   1'b1, 0, 0, 3};
      tbl[6] = '{"beq_not",    OP_BEQ,   1'b0, 0, 0, 3};
      tbl[7] = '{"j",          OP_J,     1'b0, 0, 0, 3};
      tbl[8] = '{"lw_waits",   OP_LW,    1'b0, 1, 2, 8};
      tbl[9] = '{"addi_fwait", OP_ADDI,  1'b0, 2, 0, 6};
      ops = '{OP_RTYPE, OP_LW, OP_SW, OP_ADDI, OP_BEQ, OP_J};

      rst       = 1'b1;
      mem_ready = 1'b1;
      zero      = 1'b0;
      opcode    = '0;
      funct     = '0;
      @(negedge clk);
      do_reset(2);

      for (int i = 0; i < 10; i++) begin
         run_instr(tbl[i].op, tbl[i].z, tbl[i].fw, tbl[i].mw, rc);
         check({tbl[i].name, "_cycles"}, 64'(rc), 64'(tbl[i].exp_cyc));
      end

      // Unsupported opcode traps, never retires, and is cleared only by reset.
      run_instr(OP_BAD, 1'b0, 0, 0, rc);
      check("trap_no_retire", 64'(rc), 64'(0));
      check("trap_illegal", 64'(illegal), 64'(1));
      do_reset(1);
      check("illegal_cleared", 64'(illegal), 64'(0));
      run_instr(OP_J, 1'b0, 0, 0, rc);
      check("after_trap_cycles", 64'(rc), 64'(3));

      // Reset landing in MEMRD while memory is ready: the read must be dropped.
      cyc = 0;
      ret_at = 0;
      step(P_FETCH, 1'b1, 1'b0);
      opcode = OP_LW;
      step(P_DECODE, 1'b1, 1'b0);
      step(P_MEMADR, 1'b1, 1'b0);
      do_reset(1);
      run_instr(OP_RTYPE, 1'b0, 0, 0, rc);
      check("after_abort_cycles", 64'(rc), 64'(4));

      // 17 jumps wrap the 4-bit counter to 1.
      do_reset(1);
      for (int i = 0; i < 17; i++) run_instr(OP_J, 1'b0, 0, 0, rc);
      check("wrap_w4", 64'(retired_s), 64'(1));
      check("wrap_w32", 64'(retired), 64'(17));

      for (int i = 0; i < 40; i++) begin
         logic [5:0] op;
         int         fw, mw, exp_c;
         op    = ops[$urandom_range(0, 5)];
         fw    = $urandom_range(0, 2);
         mw    = $urandom_range(0, 2);
         exp_c = base_cycles(op) + fw + ((op == OP_LW || op == OP_SW) ? mw : 0);
         run_instr(op, rb(), fw, mw, rc);
         check($sformatf("rand%0d_cycles", i), 64'(rc), 64'(exp_c));
      end

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule
